// File: rtl/layernorm_variance_stage.sv
// LayerNorm statistics stage: streams one row of N signed activations, then
// presents the row mean and the sqrt radicand (variance + EPS) behind valid/ready.
module layernorm_variance_stage #(
  parameter int N          = 64,
  parameter int LOG2N      = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int OUT_WIDTH  = 24,
  parameter int EPS        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  output logic                         x_ready,
  input  logic                         out_ready,
  output logic                         valid_out,
  output logic        [DATA_WIDTH-1:0] mean_out,
  output logic        [OUT_WIDTH-1:0]  radicand_out,
  output logic                         sat_out
);

  localparam int SUMW = DATA_WIDTH + LOG2N;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int SQW  = PW + LOG2N;
  localparam int DW   = PW + 2 * LOG2N + 1;

  // The radicand must carry the full Q.20 product fraction plus an integer bit.
  if (N != (1 << LOG2N) || OUT_WIDTH <= 2 * FRAC_BITS) begin : g_cfg_check
    $error("layernorm_variance_stage: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, HOLD} state_t;
  state_t state, state_nxt;

  logic signed [SUMW-1:0] sum;
  logic        [SQW-1:0]  sumsq;
  logic        [LOG2N:0]  cnt, cnt_nxt;
  logic                   accept, first, last;

  logic signed [PW-1:0]   x_sq;
  logic signed [SUMW-1:0] x_ext;
  logic        [SQW-1:0]  sq_ext;

  assign x_ready = (state == IDLE) || (state == ACCUM);
  assign accept  = x_valid && x_ready;
  assign first   = (state == IDLE);
  assign cnt_nxt = first ? (LOG2N+1)'(1) : cnt + (LOG2N+1)'(1);
  assign last    = accept && (cnt_nxt == (LOG2N+1)'(N));

  assign x_sq   = x_in * x_in;
  assign x_ext  = {{LOG2N{x_in[DATA_WIDTH-1]}}, x_in};
  assign sq_ext = {{LOG2N{1'b0}}, x_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last ? FINISH : ACCUM;
      ACCUM:   if (last)   state_nxt = FINISH;
      FINISH:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // First element of a row loads rather than adds, so nothing leaks across rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      sumsq <= '0;
      cnt   <= '0;
    end else if (accept) begin
      cnt <= cnt_nxt;
      if (first) begin
        sum   <= x_ext;
        sumsq <= sq_ext;
      end else begin
        sum   <= sum + x_ext;
        sumsq <= sumsq + sq_ext;
      end
    end
  end

  // N*sumsq - sum^2 is exact and non-negative; scaling by N^2 yields Q.20 variance.
  logic signed [DW-1:0] sum_w, sq_w, d;
  logic        [DW-1:0] variance, rad;
  logic                 sat;

  assign sum_w    = {{(DW-SUMW){sum[SUMW-1]}}, sum};
  assign sq_w     = {{(DW-SQW){1'b0}}, sumsq};
  assign d        = (sq_w <<< LOG2N) - sum_w * sum_w;
  assign variance = d >> (2 * LOG2N);
  assign rad      = variance + DW'(EPS);
  assign sat      = |rad[DW-1:OUT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      mean_out     <= '0;
      radicand_out <= '0;
      sat_out      <= 1'b0;
    end else if (state == FINISH) begin
      valid_out    <= 1'b1;
      mean_out     <= DATA_WIDTH'(sum >>> LOG2N);
      radicand_out <= sat ? {OUT_WIDTH{1'b1}} : rad[OUT_WIDTH-1:0];
      sat_out      <= sat;
    end else if (state == HOLD && out_ready) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layernorm_variance_stage.sv
// Bench for layernorm_variance_stage: directed rows, stall, reset abort and random
// gapped rows checked against an arithmetic model of mean and variance.
module tb_layernorm_variance_stage;
  localparam int N = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] x_in;
  logic               x_valid, x_ready, out_ready, valid_out, sat_out;
  logic        [15:0] mean_out;
  logic        [23:0] radicand_out;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int row[N];

  layernorm_variance_stage dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .out_ready(out_ready), .valid_out(valid_out), .mean_out(mean_out),
    .radicand_out(radicand_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: floor mean, exact population variance in Q.20, +EPS, clip to 24 bits.
  function automatic void model(output logic [15:0] m, output logic [23:0] r, output logic s);
    longint sm, sq, q, d, v;
    sm = 0; sq = 0;
    for (int i = 0; i < N; i++) begin
      sm += longint'(row[i]);
      sq += longint'(row[i]) * longint'(row[i]);
    end
    q = sm / N;
    if (sm < 0 && (sm % N) != 0) q = q - 1;
    m = q[15:0];
    d = sq * N - sm * sm;
    v = d / (N * N) + 1;
    if (v >= (longint'(1) << 24)) begin r = 24'hFFFFFF; s = 1'b1; end
    else begin r = v[23:0]; s = 1'b0; end
  endfunction

  task automatic fill(input int amp);
    for (int i = 0; i < N; i++) row[i] = int'($urandom_range(0, 2 * amp)) - amp;
  endtask

  // Drives the first n elements of row; gap_pct is the chance of an idle cycle before each.
  task automatic send_row(input int n, input int gap_pct, output int t0);
    int w;
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clk); x_valid = 1'b0;
      end
      @(negedge clk);
      w = 0;
      while (!x_ready && w < 50) begin @(negedge clk); w++; end
      if (i == 0) t0 = cyc;
      x_valid = 1'b1;
      x_in = row[i][15:0];
    end
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int t0, input bit chk_lat);
    logic [15:0] em; logic [23:0] er; logic es; int w;
    model(em, er, es);
    w = 0;
    while (!valid_out && w < 300) begin @(negedge clk); w++; end
    chk({tag, "_valid"}, valid_out, 1'b1);
    if (chk_lat) chk({tag, "_latency"}, cyc - t0, N + 1);
    chk({tag, "_mean"}, mean_out, em);
    chk({tag, "_radicand"}, radicand_out, er);
    chk({tag, "_sat"}, sat_out, es);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk); out_ready = 1'b1; x_valid = 1'b0;
    @(negedge clk); out_ready = 1'b0;
    chk({tag, "_valid_drop"}, valid_out, 1'b0);
    chk({tag, "_ready_back"}, x_ready, 1'b1);
  endtask

  initial begin
    int t0;
    logic [15:0] sm; logic [23:0] sr;
    rst_n = 1'b0; x_valid = 1'b0; x_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_mean", mean_out, 16'h0);
    chk("rst_radicand", radicand_out, 24'h0);
    chk("rst_sat", sat_out, 1'b0);
    chk("rst_x_ready", x_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_x_ready", x_ready, 1'b1);

    for (int i = 0; i < N; i++) row[i] = 0;
    send_row(N, 0, t0);
    check_result("zeros", t0, 1'b1);
    chk("zeros_rad_const", radicand_out, 24'h000001);
    release_result("zeros");

    for (int i = 0; i < N; i++) row[i] = 32'sh0400;
    send_row(N, 0, t0);
    check_result("ones", t0, 1'b1);
    chk("ones_mean_const", mean_out, 16'h0400);
    release_result("ones");

    for (int i = 0; i < N; i++) row[i] = (i % 2) ? -1024 : 1024;
    send_row(N, 0, t0);
    check_result("pm1", t0, 1'b1);
    chk("pm1_rad_const", radicand_out, 24'h100001);
    release_result("pm1");

    for (int i = 0; i < N; i++) row[i] = (i % 2) ? -8192 : 8192;
    send_row(N, 0, t0);
    check_result("pm8", t0, 1'b1);
    chk("pm8_rad_const", radicand_out, 24'hFFFFFF);
    chk("pm8_sat_const", sat_out, 1'b1);
    release_result("pm8");

    // Stall with x_valid held high: nothing may be consumed or change.
    fill(4096);
    send_row(N, 0, t0);
    check_result("stall", t0, 1'b1);
    sm = mean_out; sr = radicand_out;
    @(negedge clk);
    x_valid = 1'b1; x_in = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_x_ready", x_ready, 1'b0);
      chk("stall_valid", valid_out, 1'b1);
      chk("stall_mean", mean_out, sm);
      chk("stall_radicand", radicand_out, sr);
    end
    release_result("stall");
    fill(4096);
    send_row(N, 0, t0);
    check_result("after_stall", t0, 1'b1);
    release_result("after_stall");

    for (int r = 0; r < 6; r++) begin
      fill((r % 3 == 2) ? 32767 : 4096);
      send_row(N, 50, t0);
      check_result($sformatf("rand%0d", r), t0, 1'b0);
      release_result($sformatf("rand%0d", r));
    end

    // Reset mid-row: the partial row must leave no trace.
    fill(4096);
    send_row(30, 0, t0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid", valid_out, 1'b0);
    chk("abort_x_ready", x_ready, 1'b1);
    fill(4096);
    send_row(N, 0, t0);
    check_result("abort_row", t0, 1'b1);
    release_result("abort_row");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
